arm_ram_slave: RTL and testbench
================================

Name: arm_ram_slave

Overview:
- Data-memory responder for the core's ram_* initiator port.
- Accepts word, halfword and byte accesses with per-lane byte enables, and inserts a programmable number of wait states.
- Signals an abort for out-of-range or misaligned addresses.
- Sits between the core and the on-chip data SRAM; ram_ready is ANDed into the core's cpu_en at top level.

Parameters:
- DEPTH, 1024, number of 32-bit words stored (power of two, 16..65536).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned).
- WAIT_CYC, 0, wait states per access (0..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ram_addr  in  32  byte address from core
- ram_cen  in  1  access request, active high
- ram_wen  in  1  1 = write, 0 = read
- ram_flag  in  4  byte-lane enables, bit i = byte i (bits 8i+7:8i)
- ram_wdata  in  32  write data, lane-aligned
- ram_rdata  out  32  read data, registered
- ram_abort  out  1  access aborted, one-cycle pulse
- ram_ready  out  1  0 = stall core; request must be held

Behaviour:
- Reset (async, rst=1): state IDLE, ram_rdata=0, ram_abort=0, ram_ready=1, pending access discarded. Array contents are not reset.
- States: IDLE, WAIT.
- IDLE, ram_cen=1 at edge N: the request (addr, wen, flag, wdata) is latched and checked.
- Abort conditions:
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH);
  - flag in {4'b0011, 4'b1100} with addr[0]≠0;
  - flag=4'b1111 with addr[1:0]≠0;
  - any other flag with more than one bit set that is not one of those three patterns.
- WAIT_CYC=0: completion happens at edge N.
  - Write: array updated on enabled lanes only.
  - Read: ram_rdata = full addressed word, valid in cycle N+1.
  - ram_ready stays 1.
- WAIT_CYC=k>0: after edge N go to WAIT, ram_ready=0 for exactly k cycles, counter loaded with k−1 and decremented each cycle. Completion occurs at the edge where the counter is 0; then back to IDLE, ram_ready=1.
- Completion with abort: no array write, ram_rdata=0, ram_abort=1 for one cycle. Otherwise ram_abort=0.
- Completion with flag=0: no write, no abort; reads return the word.
- ram_rdata holds its last value until the next read completion. Writes leave ram_rdata unchanged.
- In WAIT, changes on ram_cen/ram_addr are ignored; the latched request is used.
- Back-to-back: the cycle ram_ready returns to 1 may carry a new request, accepted at that edge. Zero-wait throughput is 1 access per cycle.
- Word index = (ram_addr−BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
- Reset during WAIT: the access is aborted silently (no write, no abort pulse) and state returns to IDLE.

Optional Feature:
- RAM_ACCESS_CNT_EN defined: adds outputs stat_rd_cnt[15:0], stat_wr_cnt[15:0], stat_abt_cnt[15:0].
  - Each counter increments on a completed read, a completed write, or an abort respectively.
  - Counters saturate at 16'hFFFF and are cleared by rst.
- RAM_ACCESS_CNT_EN undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package arm_mem_pkg holds:
  - state encoding IDLE/WAIT;
  - flag constants FLAG_B0..B3, FLAG_H0, FLAG_H1, FLAG_W;
  - the wait-counter width constant (4).
- Sub-module arm_ram_bank: DEPTH×32 array with synchronous byte-lane write and registered read (one read/write port, no reset).
- FSM, checking and counters stay in the top module.

Test Plan:
- WAIT_CYC=0: write 32'hDEADBEEF flag 1111 addr 0x10, then read addr 0x10 → ram_rdata=32'hDEADBEEF the cycle after the read edge; ram_ready constantly 1.
- Byte lanes: write 32'h000000AA flag 0001 addr 0x20 over prior 32'h11223344, then write 32'h55660000 flag 1100 addr 0x22 → read addr 0x20 returns 32'h556633AA.
- WAIT_CYC=3: read request held → ram_ready low for exactly 3 cycles; data and ram_ready=1 appear together; second request in the ready cycle is accepted.
- Aborts:
  - addr BASE_ADDR+4*DEPTH → ram_abort one-cycle pulse, ram_rdata=0.
  - flag 1111 at addr 0x21 → abort, memory at 0x20 unchanged on readback.
- rst asserted mid-WAIT of a write (WAIT_CYC=5) → ram_ready=1 and ram_abort=0 immediately; target word unchanged on subsequent read.
- RAM_ACCESS_CNT_EN: 3 reads, 2 writes, 1 abort → counters 3/2/1; 70000 reads → stat_rd_cnt=16'hFFFF.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the core data-memory responder: FSM encoding,
// byte-lane flag patterns, wait-counter width and the access legality check.
package arm_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] FLAG_B0 = 4'b0001;
  localparam logic [3:0] FLAG_B1 = 4'b0010;
  localparam logic [3:0] FLAG_B2 = 4'b0100;
  localparam logic [3:0] FLAG_B3 = 4'b1000;
  localparam logic [3:0] FLAG_H0 = 4'b0011;
  localparam logic [3:0] FLAG_H1 = 4'b1100;
  localparam logic [3:0] FLAG_W  = 4'b1111;

  localparam int WCNT_W = 4;

  // Lane-pattern legality: single bytes (and the empty pattern) are always
  // legal, halfwords need an even address, words need a word address, and
  // every other multi-lane pattern is rejected.
  function automatic logic flag_abort(input logic [3:0] flag, input logic [1:0] lsb);
    logic bad;
    bad = 1'b1;
    case (flag)
      4'b0000, FLAG_B0, FLAG_B1, FLAG_B2, FLAG_B3: bad = 1'b0;
      FLAG_H0, FLAG_H1:                            bad = lsb[0];
      FLAG_W:                                      bad = |lsb;
      default:                                     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/arm_ram_slave_if.sv
// Core-to-data-memory bus. The core is the master, arm_ram_slave the slave.
//
// Handshake: the master raises ram_cen with addr/wen/flag/wdata. The slave
// takes the request on a rising edge where ram_ready=1 and ram_cen=1. If it
// then drops ram_ready, the master must hold the request (the slave works
// from its own copy) until ram_ready returns to 1; that cycle may already
// carry the next request. Read data and ram_abort belong to the access
// that completed on the previous edge.
interface arm_ram_slave_if;
  logic [31:0] ram_addr;
  logic        ram_cen;
  logic        ram_wen;
  logic [3:0]  ram_flag;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_abort;
  logic        ram_ready;

  modport master (
    output ram_addr, ram_cen, ram_wen, ram_flag, ram_wdata,
    input  ram_rdata, ram_abort, ram_ready
  );

  modport slave (
    input  ram_addr, ram_cen, ram_wen, ram_flag, ram_wdata,
    output ram_rdata, ram_abort, ram_ready
  );
endinterface

// File: rtl/arm_ram_bank.sv
// DEPTH x 32 single-port storage: synchronous byte-lane write, registered
// read that holds its value between reads. No reset on contents or output.
module arm_ram_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // one port: lane-masked write or full-word registered read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/arm_ram_slave.sv
// Data-memory responder for the core's ram_* port. Range and alignment
// checking, programmable wait states, registered read data, abort pulse.
// Optional access statistics are built when RAM_ACCESS_CNT_EN is defined.
module arm_ram_slave
  import arm_mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WAIT_CYC  = 0
) (
  input  logic            clk,
  input  logic            rst,
  arm_ram_slave_if.slave  bus
`ifdef RAM_ACCESS_CNT_EN
  ,
  output logic [15:0]     stat_rd_cnt,
  output logic [15:0]     stat_wr_cnt,
  output logic [15:0]     stat_abt_cnt
`endif
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [31:0]     SPAN      = 32'(DEPTH * 4);
  localparam logic            ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [WCNT_W-1:0] CNT_LOAD = WCNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   cnt_q;
  logic [31:0]         addr_q, wdata_q;
  logic                wen_q;
  logic [3:0]          flag_q;

  logic                ready, complete, accept;
  logic [31:0]         sel_addr, sel_wdata;
  logic                sel_wen;
  logic [3:0]          sel_flag;
  logic [31:0]         off;
  logic                abort_c, bank_en;
  logic [31:0]         bank_rdata;
  logic                abort_q, zero_q;

  // state register; reset drops any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: wait states only when WAIT_CYC is non-zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ram_cen && !ZERO_WAIT) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: ready, completion strobe and the request being completed
  // (live bus in IDLE for zero-wait, the latched copy in WAIT)
  always_comb begin
    ready     = (state_q == IDLE);
    accept    = (state_q == IDLE) && bus.ram_cen;
    sel_addr  = addr_q;
    sel_wen   = wen_q;
    sel_flag  = flag_q;
    sel_wdata = wdata_q;
    complete  = 1'b0;
    if (state_q == IDLE) begin
      sel_addr  = bus.ram_addr;
      sel_wen   = bus.ram_wen;
      sel_flag  = bus.ram_flag;
      sel_wdata = bus.ram_wdata;
      complete  = bus.ram_cen && ZERO_WAIT;
    end else begin
      complete  = (cnt_q == '0);
    end
  end

  // an address below BASE_ADDR wraps to a huge offset, so one compare covers both ends
  assign off     = sel_addr - BASE_ADDR;
  assign abort_c = (off >= SPAN) || flag_abort(sel_flag, sel_addr[1:0]);
  assign bank_en = complete && !abort_c && !rst;

  // request latch and wait-state down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      flag_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.ram_addr;
        wen_q   <= bus.ram_wen;
        flag_q  <= bus.ram_flag;
        wdata_q <= bus.ram_wdata;
      end
      if (accept && !ZERO_WAIT)                  cnt_q <= CNT_LOAD;
      else if (state_q == WAIT && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end
  end

  // abort pulse and read-data zeroing; zero_q masks the bank output after
  // reset or an abort until the next good read refreshes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      abort_q <= complete && abort_c;
      if (complete) begin
        if (abort_c)      zero_q <= 1'b1;
        else if (!sel_wen) zero_q <= 1'b0;
      end
    end
  end

  arm_ram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (sel_wen),
    .be    (sel_flag),
    .addr  (off[AW+1:2]),
    .wdata (sel_wdata),
    .rdata (bank_rdata)
  );

  assign bus.ram_ready = ready;
  assign bus.ram_abort = abort_q;
  assign bus.ram_rdata = zero_q ? 32'h0 : bank_rdata;

`ifdef RAM_ACCESS_CNT_EN
  // saturating completion counters: good reads, good writes, aborts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_abt_cnt <= '0;
    end else if (complete) begin
      if (abort_c) begin
        if (stat_abt_cnt != 16'hFFFF) stat_abt_cnt <= stat_abt_cnt + 16'd1;
      end else if (sel_wen) begin
        if (stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      end else begin
        if (stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arm_ram_slave.sv
// Directed bench for arm_ram_slave: three instances (0, 3 and 5 wait
// states; the last one small and at a non-zero base) driven from one
// linear sequence. Expected responses come from a small memory model and
// are queued at drive time, then popped when ready returns.
module tb_arm_ram_slave;

  logic clk;
  logic rst;

  logic [31:0] addr_s  [3];
  logic        cen_s   [3];
  logic        wen_s   [3];
  logic [3:0]  flag_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_o [3];
  logic        abort_o [3];
  logic        rdy_o   [3];
  logic [15:0] rd_cnt_o  [3];
  logic [15:0] wr_cnt_o  [3];
  logic [15:0] abt_cnt_o [3];

  int n_assert;
  int n_fail;

  logic [31:0] model   [3][64];
  logic [31:0] last_rd [3];
  logic [32:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int          WC = (g == 0) ? 0 : (g == 1) ? 3 : 5;
    localparam int          DP = (g == 2) ? 16 : 1024;
    localparam logic [31:0] BA = (g == 2) ? 32'h0001_0000 : 32'h0;

    arm_ram_slave_if bus ();

    assign bus.ram_addr  = addr_s[g];
    assign bus.ram_cen   = cen_s[g];
    assign bus.ram_wen   = wen_s[g];
    assign bus.ram_flag  = flag_s[g];
    assign bus.ram_wdata = wdata_s[g];
    assign rdata_o[g]    = bus.ram_rdata;
    assign abort_o[g]    = bus.ram_abort;
    assign rdy_o[g]      = bus.ram_ready;

`ifndef RAM_ACCESS_CNT_EN
    assign rd_cnt_o[g]  = 16'h0;
    assign wr_cnt_o[g]  = 16'h0;
    assign abt_cnt_o[g] = 16'h0;
`endif

    arm_ram_slave #(
      .DEPTH     (DP),
      .BASE_ADDR (BA),
      .WAIT_CYC  (WC)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef RAM_ACCESS_CNT_EN
      ,
      .stat_rd_cnt  (rd_cnt_o[g]),
      .stat_wr_cnt  (wr_cnt_o[g]),
      .stat_abt_cnt (abt_cnt_o[g])
`endif
    );
  end

  function automatic int wcyc(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h0001_0000 : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: called just after a negedge; returns at the negedge of the
  // cycle where ready is back, with the request still driven so the next
  // call can go back-to-back
  task automatic access(input int i, input logic [31:0] a, input logic w,
                        input logic [3:0] f, input logic [31:0] d, input logic exp_ab);
    int          n;
    int          wi;
    logic [32:0] e;
    wi = int'(((a - base_of(i)) >> 2) & 32'h3F);
    if (exp_ab) begin
      last_rd[i] = 32'h0;
    end else if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (f[b]) model[i][wi][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      last_rd[i] = model[i][wi];
    end
    exp_q.push_back({exp_ab, last_rd[i]});
    addr_s[i]  = a;
    wen_s[i]   = w;
    flag_s[i]  = f;
    wdata_s[i] = d;
    cen_s[i]   = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (rdy_o[i] !== 1'b1 && n < 40) begin
      n++;
      addr_s[i] = ~a;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("wait_cycles", 32'(n), 32'(wcyc(i)));
    check("abort", {31'h0, abort_o[i]}, {31'h0, e[32]});
    check("rdata", rdata_o[i], e[31:0]);
  endtask

  task automatic idle(input int i);
    cen_s[i] = 1'b0;
    @(negedge clk);
    check("abort_one_cycle", {31'h0, abort_o[i]}, 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_s[i]  = 32'h0;
      cen_s[i]   = 1'b0;
      wen_s[i]   = 1'b0;
      flag_s[i]  = 4'h0;
      wdata_s[i] = 32'h0;
      last_rd[i] = 32'h0;
      for (int k = 0; k < 64; k++) model[i][k] = 'x;
    end
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", {31'h0, rdy_o[i]}, 32'h1);
      check("reset_abort", {31'h0, abort_o[i]}, 32'h0);
      check("reset_rdata", rdata_o[i], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // zero wait: word write then read
    access(0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0);
    access(0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0);
    check("word_readback", rdata_o[0], 32'hDEADBEEF);

    // byte lanes, back-to-back at one access per cycle
    access(0, 32'h20, 1'b1, 4'b1111, 32'h11223344, 1'b0);
    access(0, 32'h20, 1'b1, 4'b0001, 32'h000000AA, 1'b0);
    access(0, 32'h22, 1'b1, 4'b1100, 32'h55660000, 1'b0);
    access(0, 32'h20, 1'b0, 4'b1111, 32'h0, 1'b0);
    check("lane_merge", rdata_o[0], 32'h556633AA);
    access(0, 32'h23, 1'b1, 4'b0100, 32'h00770000, 1'b0);
    access(0, 32'h20, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b0);
    access(0, 32'h20, 1'b0, 4'b0000, 32'h0, 1'b0);
    check("single_byte_lane", rdata_o[0], 32'h557733AA);

    // aborts on the zero-wait instance
    access(0, 32'h1000, 1'b0, 4'b1111, 32'h0, 1'b1);
    idle(0);
    access(0, 32'h21, 1'b1, 4'b1111, 32'h99999999, 1'b1);
    access(0, 32'h21, 1'b1, 4'b0011, 32'h99999999, 1'b1);
    access(0, 32'h20, 1'b1, 4'b0101, 32'h99999999, 1'b1);
    access(0, 32'h20, 1'b1, 4'b0110, 32'h99999999, 1'b1);
    access(0, 32'h20, 1'b0, 4'b1111, 32'h0, 1'b0);
    check("abort_no_write", rdata_o[0], 32'h557733AA);
    access(0, 32'hFFC, 1'b1, 4'b1111, 32'hCAFEBABE, 1'b0);
    access(0, 32'hFFC, 1'b0, 4'b1111, 32'h0, 1'b0);
    idle(0);

    // three wait states, second request taken in the ready cycle
    access(1, 32'h30, 1'b1, 4'b1111, 32'hA5A50F0F, 1'b0);
    access(1, 32'h30, 1'b0, 4'b1111, 32'h0, 1'b0);
    check("wait3_readback", rdata_o[1], 32'hA5A50F0F);
    access(1, 32'h1004, 1'b0, 4'b1111, 32'h0, 1'b1);
    access(1, 32'h30, 1'b1, 4'b1110, 32'h0, 1'b1);
    access(1, 32'h30, 1'b0, 4'b0001, 32'h0, 1'b0);
    idle(1);

    // five wait states, non-zero base, small depth: boundaries
    access(2, 32'h0000FFFC, 1'b0, 4'b1111, 32'h0, 1'b1);
    access(2, 32'h00010040, 1'b1, 4'b1111, 32'h0, 1'b1);
    access(2, 32'h0001003C, 1'b1, 4'b1111, 32'h0BADF00D, 1'b0);
    access(2, 32'h00010008, 1'b1, 4'b1111, 32'h12345678, 1'b0);
    access(2, 32'h0001003C, 1'b0, 4'b1111, 32'h0, 1'b0);
    idle(2);

    // reset in the middle of a waiting write
    addr_s[2]  = 32'h00010008;
    wen_s[2]   = 1'b1;
    flag_s[2]  = 4'b1111;
    wdata_s[2] = 32'hCAFEF00D;
    cen_s[2]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midwait_ready_low", {31'h0, rdy_o[2]}, 32'h0);
    rst      = 1'b1;
    cen_s[2] = 1'b0;
    #1;
    check("rst_ready", {31'h0, rdy_o[2]}, 32'h1);
    check("rst_abort", {31'h0, abort_o[2]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    @(negedge clk);
    check("post_rst_abort", {31'h0, abort_o[2]}, 32'h0);
    access(2, 32'h00010008, 1'b0, 4'b1111, 32'h0, 1'b0);
    check("rst_write_dropped", rdata_o[2], 32'h12345678);
    idle(2);

`ifdef RAM_ACCESS_CNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    check("cnt_clear_rd", {16'h0, rd_cnt_o[0]}, 32'h0);
    check("cnt_clear_abt", {16'h0, abt_cnt_o[0]}, 32'h0);
    access(0, 32'h40, 1'b1, 4'b1111, 32'h01020304, 1'b0);
    access(0, 32'h44, 1'b1, 4'b0010, 32'h0000EE00, 1'b0);
    access(0, 32'h40, 1'b0, 4'b1111, 32'h0, 1'b0);
    access(0, 32'h2000, 1'b0, 4'b1111, 32'h0, 1'b1);
    access(0, 32'h40, 1'b0, 4'b1111, 32'h0, 1'b0);
    access(0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0);
    idle(0);
    check("cnt_rd", {16'h0, rd_cnt_o[0]}, 32'd3);
    check("cnt_wr", {16'h0, wr_cnt_o[0]}, 32'd2);
    check("cnt_abt", {16'h0, abt_cnt_o[0]}, 32'd1);
    addr_s[0] = 32'h10;
    wen_s[0]  = 1'b0;
    flag_s[0] = 4'b1111;
    cen_s[0]  = 1'b1;
    repeat (70000) @(posedge clk);
    cen_s[0] = 1'b0;
    @(negedge clk);
    check("cnt_rd_saturate", {16'h0, rd_cnt_o[0]}, 32'h0000FFFF);
    check("cnt_wr_after_sat", {16'h0, wr_cnt_o[0]}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
